// File: rtl/mem_sram_bridge_pkg.sv
// Shared types and helpers for the cache-to-SRAM bridge.
// The window helper is used only when MEM_SRAM_BRIDGE_RANGE_CHECK_EN is defined.
package mem_sram_bridge_pkg;

    localparam int WAIT_CNT_W = 4;

    typedef enum logic [2:0] {
        IDLE,
        ACCESS,
        CAPTURE,
        WAIT,
        RESP
    } state_t;

    // The upper bound is computed in 33 bits so that a window ending at 4 GiB cannot wrap.
    function automatic logic addr_in_window(input logic [31:0] addr,
                                            input logic [31:0] base,
                                            input int unsigned aw);
        logic [32:0] lo;
        logic [32:0] hi;
        logic [32:0] a;
        lo = {1'b0, base};
        hi = lo + (33'd4 << aw);
        a  = {1'b0, addr};
        return (a >= lo) && (a < hi);
    endfunction

endpackage

// File: rtl/mem_sram_wait_cnt.sv
// Wait-state down-counter: load a start value, decrement to zero, then hold at zero.
module mem_sram_wait_cnt
    import mem_sram_bridge_pkg::*;
(
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  load,
    input  logic [WAIT_CNT_W-1:0] load_val,
    input  logic                  dec,
    output logic                  done
);

    logic [WAIT_CNT_W-1:0] count_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
        end else if (load) begin
            count_q <= load_val;
        end else if (dec && (count_q != '0)) begin
            count_q <= count_q - 1'b1;
        end
    end

    assign done = (count_q == '0);

endmodule

// File: rtl/mem_sram_bridge.sv
// Cache memory-bus to single-port synchronous SRAM bridge, one outstanding transaction.
// Optional address window check: MEM_SRAM_BRIDGE_RANGE_CHECK_EN.
//
// state   | meaning
// IDLE    | waiting for a request; only state in which gnt can be high
// ACCESS  | SRAM enabled with the captured address, write enables and data
// CAPTURE | SRAM read data sampled into the response register
// WAIT    | programmable wait states before the response
// RESP    | one-cycle rvalid with rdata and error
module mem_sram_bridge
    import mem_sram_bridge_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH  = 12,
    parameter logic [31:0] BASE_ADDR   = 32'h0010_0000,
    parameter int unsigned WAIT_STATES = 0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  mem_req_i,
    input  logic [31:0]           mem_addr_i,
    input  logic                  mem_we_i,
    input  logic [3:0]            mem_be_i,
    input  logic [31:0]           mem_wdata_i,
    output logic                  mem_gnt_o,
    output logic                  mem_rvalid_o,
    output logic [31:0]           mem_rdata_o,
    output logic                  mem_error_o,
    output logic                  sram_en_o,
    output logic [3:0]            sram_we_o,
    output logic [ADDR_WIDTH-1:0] sram_addr_o,
    output logic [31:0]           sram_wdata_o,
    input  logic [31:0]           sram_rdata_i
);

    localparam logic [WAIT_CNT_W-1:0] WAIT_LOAD =
        (WAIT_STATES == 0) ? '0 : WAIT_CNT_W'(WAIT_STATES - 1);

    state_t                state_q;
    state_t                state_d;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic                  we_q;
    logic [3:0]            be_q;
    logic [31:0]           wdata_q;
    logic [31:0]           rdata_q;
    logic [31:0]           rdata_out_q;
    logic [31:0]           rdata_next;
    logic                  err_q;
    logic                  accept;
    logic                  range_err;
    logic                  access;
    logic                  cnt_load;
    logic                  cnt_dec;
    logic                  cnt_done;
    logic                  unused_bits;

    assign mem_gnt_o = mem_req_i & (state_q == IDLE) & ~reset;
    assign accept    = mem_gnt_o;

`ifdef MEM_SRAM_BRIDGE_RANGE_CHECK_EN
    assign range_err   = ~addr_in_window(mem_addr_i, BASE_ADDR, ADDR_WIDTH);
    assign unused_bits = ^mem_addr_i[1:0];
`else
    assign range_err   = 1'b0;
    assign unused_bits = ^{mem_addr_i[31:ADDR_WIDTH+2], mem_addr_i[1:0], BASE_ADDR, err_q};
`endif

    always_comb begin
        state_d    = state_q;
        cnt_load   = 1'b0;
        cnt_dec    = 1'b0;
        rdata_next = rdata_out_q;
        case (state_q)
            IDLE: begin
                rdata_next = 32'b0;
                if (accept) state_d = range_err ? RESP : ACCESS;
            end
            ACCESS: state_d = CAPTURE;
            CAPTURE: begin
                rdata_next = we_q ? 32'b0 : sram_rdata_i;
                if (WAIT_STATES == 0) begin
                    state_d = RESP;
                end else begin
                    state_d  = WAIT;
                    cnt_load = 1'b1;
                end
            end
            WAIT: begin
                rdata_next = rdata_q;
                if (cnt_done) state_d = RESP;
                else          cnt_dec = 1'b1;
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // rdata_o only changes on entry to RESP, so it holds its value between responses.
    always_ff @(posedge clk) begin
        if (reset) begin
            addr_q      <= '0;
            we_q        <= 1'b0;
            be_q        <= 4'b0;
            wdata_q     <= 32'b0;
            rdata_q     <= 32'b0;
            rdata_out_q <= 32'b0;
            err_q       <= 1'b0;
        end else begin
            if (accept) begin
                addr_q  <= mem_addr_i[ADDR_WIDTH+1:2];
                we_q    <= mem_we_i;
                be_q    <= mem_be_i;
                wdata_q <= mem_wdata_i;
                err_q   <= range_err;
            end
            if (state_q == CAPTURE) rdata_q <= we_q ? 32'b0 : sram_rdata_i;
            if ((state_d == RESP) && (state_q != RESP)) rdata_out_q <= rdata_next;
        end
    end

    mem_sram_wait_cnt u_wait_cnt (
        .clk      (clk),
        .reset    (reset),
        .load     (cnt_load),
        .load_val (WAIT_LOAD),
        .dec      (cnt_dec),
        .done     (cnt_done)
    );

    // Gated with reset so an aborted transaction cannot touch the SRAM in the reset cycle.
    assign access       = (state_q == ACCESS) & ~reset;
    assign sram_en_o    = access;
    assign sram_we_o    = (access && we_q) ? be_q : 4'b0;
    assign sram_addr_o  = access ? addr_q : '0;
    assign sram_wdata_o = access ? wdata_q : 32'b0;

    assign mem_rvalid_o = (state_q == RESP) & ~reset;
    assign mem_rdata_o  = rdata_out_q;
`ifdef MEM_SRAM_BRIDGE_RANGE_CHECK_EN
    assign mem_error_o  = mem_rvalid_o & err_q;
`else
    assign mem_error_o  = 1'b0;
`endif

endmodule

// File: tb/tb_mem_sram_bridge.sv
// Self-checking bench: two bridges (0 and 3 wait states), each with its own SRAM model,
// driven by directed and random transactions against a word-array reference memory.
module tb_mem_sram_bridge;

    localparam int          AW    = 12;
    localparam int          WORDS = 1 << AW;
    localparam logic [31:0] BASE  = 32'h0010_0000;
`ifdef MEM_SRAM_BRIDGE_RANGE_CHECK_EN
    localparam bit          RC    = 1'b1;
`else
    localparam bit          RC    = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    logic [1:0]    req, we, gnt, rvalid, err, sram_en;
    logic [31:0]   addr[2], wdata[2], rdata[2], sram_wdata[2], sram_rdata[2];
    logic [3:0]    be[2], sram_we[2];
    logic [AW-1:0] sram_addr[2];

    int n_chk = 0;
    int n_bad = 0;

    mem_sram_bridge #(.ADDR_WIDTH(AW), .BASE_ADDR(BASE), .WAIT_STATES(0)) dut0 (
        .clk(clk), .reset(reset),
        .mem_req_i(req[0]), .mem_addr_i(addr[0]), .mem_we_i(we[0]), .mem_be_i(be[0]),
        .mem_wdata_i(wdata[0]), .mem_gnt_o(gnt[0]), .mem_rvalid_o(rvalid[0]),
        .mem_rdata_o(rdata[0]), .mem_error_o(err[0]), .sram_en_o(sram_en[0]),
        .sram_we_o(sram_we[0]), .sram_addr_o(sram_addr[0]), .sram_wdata_o(sram_wdata[0]),
        .sram_rdata_i(sram_rdata[0])
    );

    mem_sram_bridge #(.ADDR_WIDTH(AW), .BASE_ADDR(BASE), .WAIT_STATES(3)) dut3 (
        .clk(clk), .reset(reset),
        .mem_req_i(req[1]), .mem_addr_i(addr[1]), .mem_we_i(we[1]), .mem_be_i(be[1]),
        .mem_wdata_i(wdata[1]), .mem_gnt_o(gnt[1]), .mem_rvalid_o(rvalid[1]),
        .mem_rdata_o(rdata[1]), .mem_error_o(err[1]), .sram_en_o(sram_en[1]),
        .sram_we_o(sram_we[1]), .sram_addr_o(sram_addr[1]), .sram_wdata_o(sram_wdata[1]),
        .sram_rdata_i(sram_rdata[1])
    );

    function automatic int ws(input int k);
        return (k == 0) ? 0 : 3;
    endfunction

    function automatic logic [31:0] init_word(input int k, input int i);
        if (k == 0 && i == 5) return 32'hDEAD_BEEF;
        if (k == 0 && i == 2) return 32'h1122_3344;
        return (32'(i) * 32'h9E37_79B1) ^ ((k == 0) ? 32'h0F0F_5A5A : 32'h5A5A_0F0F);
    endfunction

    function automatic logic model_oow(input logic [31:0] a);
        longint unsigned aa;
        aa = 64'(a);
        return RC && ((aa < 64'(BASE)) || (aa >= 64'(BASE) + 64'(4 * WORDS)));
    endfunction

    // Behavioural synchronous SRAM: one-cycle read latency, byte-lane writes.
    logic        mem_init;
    logic [31:0] sram_mem[2][WORDS];
    always @(posedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (mem_init) begin
                for (int i = 0; i < WORDS; i++) sram_mem[k][i] <= init_word(k, i);
            end else if (sram_en[k]) begin
                for (int b = 0; b < 4; b++)
                    if (sram_we[k][b]) sram_mem[k][sram_addr[k]][8*b +: 8] <= sram_wdata[k][8*b +: 8];
                sram_rdata[k] <= sram_mem[k][sram_addr[k]];
            end
        end
    end

    logic [31:0] ref_mem[2][WORDS];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // Protocol monitor: no back-to-back rvalid, no grant while a transaction is in flight.
    logic [1:0] busy = 2'b0;
    logic [1:0] prev_rv = 2'b0;
    always @(negedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (reset) begin
                busy[k]    <= 1'b0;
                prev_rv[k] <= 1'b0;
            end else begin
                chk("rvalid_twice", 32'(rvalid[k] & prev_rv[k]), 32'd0);
                chk("gnt_while_busy", 32'(gnt[k] & busy[k]), 32'd0);
                prev_rv[k] <= rvalid[k];
                if (rvalid[k])   busy[k] <= 1'b0;
                else if (gnt[k]) busy[k] <= 1'b1;
            end
        end
    end

    task automatic txn(input int k, input logic w, input logic [31:0] a, input logic [3:0] b,
                       input logic [31:0] d, output logic [31:0] rd_obs);
        logic          oow;
        logic [AW-1:0] word;
        logic [31:0]   exp_rd;
        int            exp_lat;
        int            n;
        bit            got;
        oow     = model_oow(a);
        word    = a[AW+1:2];
        exp_rd  = (w || oow) ? 32'b0 : ref_mem[k][word];
        exp_lat = oow ? 1 : 3 + ws(k);
        if (w && !oow)
            for (int i = 0; i < 4; i++)
                if (b[i]) ref_mem[k][word][8*i +: 8] = d[8*i +: 8];
        rd_obs = 32'hx;
        @(posedge clk); #1;
        req[k] = 1'b1; we[k] = w; addr[k] = a; be[k] = b; wdata[k] = d;
        @(negedge clk);
        chk("gnt", 32'(gnt[k]), 32'd1);
        @(posedge clk); #1;
        req[k] = 1'b0; we[k] = 1'($urandom); addr[k] = $urandom; be[k] = 4'($urandom);
        wdata[k] = $urandom;
        n = 1;
        got = 1'b0;
        while (!got && n <= 25) begin
            @(negedge clk);
            if (n == 1) begin
                chk("sram_en", 32'(sram_en[k]), 32'(!oow));
                if (!oow) begin
                    chk("sram_we", 32'(sram_we[k]), w ? 32'(b) : 32'd0);
                    chk("sram_addr", 32'(sram_addr[k]), 32'(word));
                    if (w) chk("sram_wdata", sram_wdata[k], d);
                end
            end else begin
                chk("sram_en_idle", 32'(sram_en[k]), 32'd0);
            end
            if (rvalid[k]) begin
                got = 1'b1;
                rd_obs = rdata[k];
                chk("latency", 32'(n), 32'(exp_lat));
                chk("rdata", rdata[k], exp_rd);
                chk("error", 32'(err[k]), 32'(oow));
            end else begin
                n++;
            end
        end
        if (!got) chk("rvalid_timeout", 32'd0, 32'd1);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [31:0] rd;
        logic [31:0] a;
        int          gt[3];
        int          got_n;
        int          cyc;
        bit          rv_seen;
        int          r;

        req = 2'b0; we = 2'b0;
        for (int k = 0; k < 2; k++) begin
            addr[k] = 32'b0; be[k] = 4'b0; wdata[k] = 32'b0;
            for (int i = 0; i < WORDS; i++) ref_mem[k][i] = init_word(k, i);
        end
        mem_init = 1'b1;
        repeat (3) @(posedge clk);
        #1 mem_init = 1'b0;
        req = 2'b11;

        // Reset state, with requests pending: gnt must stay low while reset is high.
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            chk("rst_gnt", 32'(gnt[k]), 32'd0);
            chk("rst_rvalid", 32'(rvalid[k]), 32'd0);
            chk("rst_error", 32'(err[k]), 32'd0);
            chk("rst_rdata", rdata[k], 32'd0);
            chk("rst_sram_en", 32'(sram_en[k]), 32'd0);
            chk("rst_sram_we", 32'(sram_we[k]), 32'd0);
            chk("rst_sram_addr", 32'(sram_addr[k]), 32'd0);
            chk("rst_sram_wdata", sram_wdata[k], 32'd0);
        end
        @(posedge clk); #1;
        req = 2'b00;
        reset = 1'b0;

        txn(0, 1'b0, BASE + 32'h14, 4'h0, 32'h0, rd);
        chk("t1_rdata", rd, 32'hDEAD_BEEF);

        txn(0, 1'b1, BASE + 32'h8, 4'b0101, 32'hAABB_CCDD, rd);
        txn(0, 1'b0, BASE + 32'h8, 4'h0, 32'h0, rd);
        chk("t2_merge", rd, 32'h11BB_33DD);

        txn(1, 1'b0, BASE + 32'h14, 4'h0, 32'h0, rd);

        // Held request on the 3-wait-state bridge: grants every 7 cycles.
        got_n = 0;
        cyc = 0;
        @(posedge clk); #1;
        req[1] = 1'b1; we[1] = 1'b0; addr[1] = BASE + 32'h14;
        while (got_n < 3 && cyc < 40) begin
            @(negedge clk);
            if (gnt[1]) begin
                gt[got_n] = cyc;
                got_n++;
            end
            if (got_n < 3) begin
                @(posedge clk); #1;
                cyc++;
            end
        end
        @(posedge clk); #1;
        req[1] = 1'b0;
        chk("b2b_count", 32'(got_n), 32'd3);
        if (got_n == 3) begin
            chk("b2b_gap1", 32'(gt[1] - gt[0]), 32'd7);
            chk("b2b_gap2", 32'(gt[2] - gt[1]), 32'd7);
        end
        repeat (10) @(posedge clk);

        // Reset during CAPTURE of a read aborts it.
        @(posedge clk); #1;
        req[0] = 1'b1; we[0] = 1'b0; addr[0] = BASE + 32'h14;
        @(negedge clk);
        chk("t4_gnt", 32'(gnt[0]), 32'd1);
        @(posedge clk); #1;
        req[0] = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        chk("t4_rvalid", 32'(rvalid[0]), 32'd0);
        chk("t4_error", 32'(err[0]), 32'd0);
        chk("t4_rdata", rdata[0], 32'd0);
        chk("t4_gnt_idle", 32'(gnt[0]), 32'd0);
        chk("t4_sram_en", 32'(sram_en[0]), 32'd0);
        chk("t4_sram_we", 32'(sram_we[0]), 32'd0);
        chk("t4_sram_addr", 32'(sram_addr[0]), 32'd0);
        chk("t4_sram_wdata", sram_wdata[0], 32'd0);
        rv_seen = 1'b0;
        repeat (10) begin
            @(negedge clk);
            rv_seen = rv_seen | rvalid[0];
        end
        chk("t4_no_rvalid", 32'(rv_seen), 32'd0);
        txn(0, 1'b0, BASE + 32'h14, 4'h0, 32'h0, rd);

        // Just past the window: error with range check, alias to word 0 without.
        txn(0, 1'b1, BASE + 32'h4000, 4'hF, 32'hCAFE_F00D, rd);
        txn(0, 1'b0, BASE, 4'h0, 32'h0, rd);
        txn(0, 1'b0, BASE - 32'h4, 4'h0, 32'h0, rd);

        for (int k = 0; k < 2; k++) begin
            for (int t = 0; t < 40; t++) begin
                r = $urandom_range(0, 9);
                if (r == 0)      a = $urandom;
                else if (r == 1) a = BASE + 32'(4 * WORDS) - 32'h4 + 32'($urandom_range(0, 3));
                else if (r == 2) a = BASE - 32'($urandom_range(1, 8));
                else             a = BASE + 32'($urandom_range(0, 15) << 2) + 32'($urandom_range(0, 3));
                txn(k, 1'($urandom), a, 4'($urandom), $urandom, rd);
            end
        end

        repeat (3) @(posedge clk);
        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
